// File: rtl/lane_queue_counter_pkg.sv
// Shared types and defaults for the lane queue counter: request FSM states,
// default geometry and the width of the requested-lane index.
package lane_queue_counter_pkg;

    localparam int DEF_LANES  = 4;
    localparam int DEF_WIDTH  = 4;
    localparam int DEF_THRESH = 8;
    localparam int REQ_LANE_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVE
    } state_t;

endpackage

// File: rtl/lane_counter.sv
// One lane: saturating up/down car counter with sticky overflow (arrival lost
// at MAX) and underflow (departure attempted at 0) flags.
module lane_counter
    import lane_queue_counter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_arrive,
    input  logic             i_depart,
    input  logic             i_clear,
    output logic [WIDTH-1:0] o_count,
    output logic             o_ovf,
    output logic             o_udf
);

    localparam logic [WIDTH-1:0] MAX = '1;

    logic [WIDTH-1:0] r_count;
    logic             r_ovf;
    logic             r_udf;

    logic w_inc;
    logic w_dec;
    logic w_set_ovf;
    logic w_set_udf;

    // A simultaneous arrival and departure cancel out and never raise a flag.
    assign w_inc     = i_arrive & ~i_depart;
    assign w_dec     = i_depart & ~i_arrive;
    assign w_set_ovf = w_inc & (r_count == MAX);
    assign w_set_udf = w_dec & (r_count == '0);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            if (w_inc && !w_set_ovf) begin
                r_count <= r_count + 1'b1;
            end else if (w_dec && !w_set_udf) begin
                r_count <= r_count - 1'b1;
            end
            r_ovf <= w_set_ovf | (r_ovf & ~i_clear);
            r_udf <= w_set_udf | (r_udf & ~i_clear);
        end
    end

    assign o_count = r_count;
    assign o_ovf   = r_ovf;
    assign o_udf   = r_udf;

endmodule

// File: rtl/lane_queue_counter.sv
// Per-lane queue counters plus a request FSM that asks the light controller
// to serve the fullest lane once any lane reaches THRESH.
module lane_queue_counter
    import lane_queue_counter_pkg::*;
#(
    parameter int LANES  = DEF_LANES,
    parameter int WIDTH  = DEF_WIDTH,
    parameter int THRESH = DEF_THRESH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic [LANES-1:0]        car_in,
    input  logic [LANES-1:0]        green,
    input  logic                    depart_tick,
    input  logic                    clear_flags,
    output logic [LANES*WIDTH-1:0]  count,
    output logic [LANES-1:0]        empty,
    output logic [LANES-1:0]        full,
    output logic [LANES-1:0]        ovf,
    output logic [LANES-1:0]        udf,
    output logic                    req_valid,
    output logic [REQ_LANE_W-1:0]   req_lane,
    input  logic                    req_ready
);

    localparam logic [WIDTH-1:0] THR = WIDTH'(THRESH);

    logic [WIDTH-1:0]      w_cnt [LANES];
    logic [WIDTH-1:0]      w_best_cnt;
    logic [REQ_LANE_W-1:0] w_best_lane;
    logic                  w_any_hot;
    logic                  w_sel_green;
    logic                  w_sel_empty;

    state_t                r_state;
    state_t                w_next_state;
    logic [REQ_LANE_W-1:0] r_req_lane;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        lane_counter #(.WIDTH(WIDTH)) u_lane (
            .clk      (clk),
            .reset    (reset),
            .i_arrive (en & car_in[g]),
            .i_depart (en & depart_tick & green[g]),
            .i_clear  (en & clear_flags),
            .o_count  (w_cnt[g]),
            .o_ovf    (ovf[g]),
            .o_udf    (udf[g])
        );
        assign count[g*WIDTH +: WIDTH] = w_cnt[g];
        assign empty[g] = (w_cnt[g] == '0);
        assign full[g]  = &w_cnt[g];
    end

    // Strict '>' keeps the lowest index on ties.
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_best_cnt  = w_cnt[0];
        w_best_lane = '0;
        w_any_hot   = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (w_cnt[i] >= THR) w_any_hot = 1'b1;
            if (w_cnt[i] > w_best_cnt) begin
                w_best_cnt  = w_cnt[i];
                w_best_lane = REQ_LANE_W'(i);
            end
        end
    end

    always_comb begin
        w_sel_green = 1'b0;
        w_sel_empty = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (r_req_lane == REQ_LANE_W'(i)) begin
                w_sel_green = green[i];
                w_sel_empty = empty[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_req_lane <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == IDLE && w_any_hot) r_req_lane <= w_best_lane;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_any_hot) w_next_state = REQ;
            REQ:     if (req_ready) w_next_state = SERVE;
            SERVE:   if (!w_sel_green || w_sel_empty) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        req_valid = (r_state == REQ);
        req_lane  = r_req_lane;
    end

endmodule

// File: tb/tb_lane_queue_counter.sv
// Scoreboard bench: a driver applies stimulus and queues the expected state
// from a behavioural model; a monitor compares after each clock edge.
module tb_lane_queue_counter;

    localparam int LANES  = 4;
    localparam int WIDTH  = 4;
    localparam int THRESH = 8;
    localparam int MAX    = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, en, depart_tick, clear_flags, req_ready;
    logic [3:0]  car_in, green;
    logic [15:0] count;
    logic [3:0]  empty, full, ovf, udf;
    logic        req_valid;
    logic [2:0]  req_lane;

    lane_queue_counter #(.LANES(LANES), .WIDTH(WIDTH), .THRESH(THRESH)) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .car_in      (car_in),
        .green       (green),
        .depart_tick (depart_tick),
        .clear_flags (clear_flags),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .ovf         (ovf),
        .udf         (udf),
        .req_valid   (req_valid),
        .req_lane    (req_lane),
        .req_ready   (req_ready)
    );

    typedef struct packed {
        logic [15:0] cnt;
        logic [3:0]  ovf;
        logic [3:0]  udf;
        logic        valid;
        logic [2:0]  lane;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Model state: plain integer counts, and the request as "none / waiting
    // for acceptance / being served" plus the chosen lane.
    int m_cnt [LANES];
    bit m_ovf [LANES];
    bit m_udf [LANES];
    int m_mode;
    int m_lane;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit rst, input bit e, input logic [3:0] car,
                              input logic [3:0] gr, input bit dep, input bit clr,
                              input bit rdy);
        exp_t x;
        if (rst) begin
            for (int i = 0; i < LANES; i++) begin
                m_cnt[i] = 0; m_ovf[i] = 0; m_udf[i] = 0;
            end
            m_mode = 0;
            m_lane = 0;
        end else begin
            if (m_mode == 0) begin
                int hi = 0;
                for (int i = 0; i < LANES; i++) if (m_cnt[i] > hi) hi = m_cnt[i];
                if (hi >= THRESH) begin
                    m_mode = 1;
                    for (int i = LANES - 1; i >= 0; i--) if (m_cnt[i] == hi) m_lane = i;
                end
            end else if (m_mode == 1) begin
                if (rdy) m_mode = 2;
            end else begin
                if (!gr[m_lane] || m_cnt[m_lane] == 0) m_mode = 0;
            end
            for (int i = 0; i < LANES; i++) begin
                bit a = e & car[i];
                bit d = e & dep & gr[i];
                if (e && clr) begin m_ovf[i] = 0; m_udf[i] = 0; end
                if (a && !d) begin
                    if (m_cnt[i] == MAX) m_ovf[i] = 1; else m_cnt[i] = m_cnt[i] + 1;
                end else if (d && !a) begin
                    if (m_cnt[i] == 0) m_udf[i] = 1; else m_cnt[i] = m_cnt[i] - 1;
                end
            end
        end
        for (int i = 0; i < LANES; i++) begin
            x.cnt[i*4 +: 4] = 4'(m_cnt[i]);
            x.ovf[i] = m_ovf[i];
            x.udf[i] = m_udf[i];
        end
        x.valid = (m_mode == 1);
        x.lane  = 3'(m_lane);
        sb_q.push_back(x);
    endtask

    task automatic step(input bit rst, input bit e, input logic [3:0] car,
                        input logic [3:0] gr, input bit dep, input bit clr,
                        input bit rdy);
        reset = rst; en = e; car_in = car; green = gr;
        depart_tick = dep; clear_flags = clr; req_ready = rdy;
        model_edge(rst, e, car, gr, dep, clr, rdy);
        @(posedge clk);
        #2;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                exp_t x;
                x = sb_q.pop_front();
                for (int i = 0; i < LANES; i++) begin
                    check($sformatf("count%0d", i), int'(count[i*4 +: 4]), int'(x.cnt[i*4 +: 4]));
                    check($sformatf("empty%0d", i), int'(empty[i]), int'(x.cnt[i*4 +: 4] == 4'd0));
                    check($sformatf("full%0d", i), int'(full[i]), int'(x.cnt[i*4 +: 4] == 4'd15));
                    check($sformatf("ovf%0d", i), int'(ovf[i]), int'(x.ovf[i]));
                    check($sformatf("udf%0d", i), int'(udf[i]), int'(x.udf[i]));
                end
                check("req_valid", int'(req_valid), int'(x.valid));
                if (x.valid) check("req_lane", int'(req_lane), int'(x.lane));
            end
        end
    end

    initial begin
        // Saturation at MAX on lane 0.
        step(1, 0, 4'h0, 4'h0, 0, 0, 0);
        check("reset_req_lane", int'(req_lane), 0);
        repeat (14) step(0, 1, 4'h1, 4'h0, 0, 0, 0);
        repeat (3)  step(0, 1, 4'h1, 4'h0, 0, 0, 0);
        check("sat_full0", int'(full[0]), 1);
        check("sat_ovf0", int'(ovf[0]), 1);

        // Saturation at 0 on lane 1.
        step(1, 0, 4'h0, 4'h0, 0, 0, 0);
        step(0, 1, 4'h2, 4'h0, 0, 0, 0);
        repeat (3) step(0, 1, 4'h0, 4'h2, 1, 0, 0);
        check("sat_udf1", int'(udf[1]), 1);

        // Coincident arrival and departure at 0 and at MAX on lane 2.
        step(1, 0, 4'h0, 4'h0, 0, 0, 0);
        step(0, 1, 4'h4, 4'h4, 1, 0, 0);
        repeat (15) step(0, 1, 4'h4, 4'h0, 0, 0, 0);
        step(0, 1, 4'h4, 4'h4, 1, 0, 0);
        check("both_ovf2", int'(ovf[2]), 0);

        // Tie-break, held lane, handshake and release on green.
        step(1, 0, 4'h0, 4'h0, 0, 0, 0);
        repeat (9) step(0, 1, 4'ha, 4'h2, 0, 0, 0);
        step(0, 1, 4'h0, 4'h2, 0, 0, 0);
        check("tie_lane", int'(req_lane), 1);
        repeat (3) step(0, 1, 4'h8, 4'h2, 0, 0, 0);
        check("held_lane", int'(req_lane), 1);
        step(0, 1, 4'h0, 4'h2, 0, 0, 1);
        step(0, 1, 4'h0, 4'h2, 0, 0, 0);
        step(0, 1, 4'h0, 4'h0, 0, 0, 0);
        step(0, 1, 4'h0, 4'h0, 0, 0, 0);

        // Reset mid-request, then en=0 holds counts.
        step(1, 0, 4'h0, 4'h0, 0, 0, 0);
        repeat (10) step(0, 1, 4'hf, 4'h0, 0, 0, 0);
        step(0, 1, 4'h0, 4'h0, 0, 0, 1);
        step(1, 1, 4'hf, 4'hf, 1, 0, 1);
        check("rst_counts", int'(count), 0);
        repeat (5) step(0, 1, 4'h3, 4'h0, 0, 0, 0);
        repeat (4) step(0, 0, 4'hf, 4'hf, 1, 1, 1);

        // Randomised phases alternating arrival- and departure-heavy traffic.
        for (int k = 0; k < 3000; k++) begin
            bit e   = ($urandom % 8) != 0;
            bit dep = ((k / 200) % 2 == 1) ? (($urandom % 4) != 0) : (($urandom % 4) == 0);
            bit clr = e && (($urandom % 16) == 0);
            bit rst = ($urandom % 300) == 0;
            step(rst, e, 4'($urandom), 4'($urandom), dep, clr, ($urandom % 3) == 0);
        end

        @(posedge clk);
        #3;
        check("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
